// File: rtl/msg_tx_sequencer.sv
// Streams a NUL-terminated ROM message into a valid/ready TX sink; MSG_CRLF_EN appends CR LF after NUL.
// Latency: trigger sampled at edge t, FETCH (o_busy, o_rom_next) from edge t+1; 3 cycles minimum per byte.
// Backpressure: each byte is held stable in o_tx_data until i_tx_ready; ROM waits are unbounded.
module msg_tx_sequencer #(
    parameter int PERIOD  = 12000000,
    parameter int MAX_LEN = 100
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_start,
    input  logic        i_auto,
    output logic        o_rom_next,
    input  logic        i_rom_act,
    input  logic [7:0]  i_rom_data,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun,
    output logic [15:0] o_msg_count
);

    localparam int CW = $clog2(MAX_LEN + 1);
    localparam int TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LEN_MAX = CW'(MAX_LEN);
    localparam logic [TW-1:0] T_LAST  = TW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT_ROM, S_SEND, S_EOL_CR, S_EOL_LF, S_DONE
    } state_t;

    state_t          state, state_nxt;
    logic            pending;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      tx_data;
    logic            tx_valid;
    logic            overrun;
    logic [15:0]     msg_count;
    logic            trig;
    logic            hs;
    logic            timer_wrap;

    assign timer_wrap = (timer == T_LAST);
    assign trig       = i_start | (i_auto & timer_wrap);
    assign hs         = tx_valid & i_tx_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (pending) state_nxt = S_FETCH;
            S_FETCH:    state_nxt = S_WAIT_ROM;
            S_WAIT_ROM: begin
                if (i_rom_act) begin
                    if (i_rom_data == 8'h00) begin
`ifdef MSG_CRLF_EN
                        state_nxt = S_EOL_CR;
`else
                        state_nxt = S_DONE;
`endif
                    end else begin
                        state_nxt = S_SEND;
                    end
                end
            end
            S_SEND:     if (hs) state_nxt = (byte_cnt == LEN_MAX) ? S_DONE : S_FETCH;
`ifdef MSG_CRLF_EN
            S_EOL_CR:   if (hs) state_nxt = S_EOL_LF;
            S_EOL_LF:   if (hs) state_nxt = S_DONE;
`endif
            S_DONE:     state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending   <= 1'b0;
            timer     <= '0;
            byte_cnt  <= '0;
            tx_data   <= 8'h00;
            tx_valid  <= 1'b0;
            overrun   <= 1'b0;
            msg_count <= 16'd0;
        end else begin
            timer <= timer_wrap ? '0 : timer + 1'b1;
            // A trigger landing in the cycle we leave IDLE queues the next message
            if (state == S_IDLE && pending) pending <= trig;
            else                            pending <= pending | trig;

            case (state)
                S_IDLE: if (pending) byte_cnt <= '0;
                S_WAIT_ROM: begin
                    if (i_rom_act) begin
                        if (i_rom_data != 8'h00) begin
                            tx_data  <= i_rom_data;
                            tx_valid <= 1'b1;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
`ifdef MSG_CRLF_EN
                        else begin
                            tx_data  <= 8'h0D;
                            tx_valid <= 1'b1;
                        end
`endif
                    end
                end
                S_SEND: begin
                    if (hs) begin
                        tx_valid <= 1'b0;
                        if (byte_cnt == LEN_MAX) overrun <= 1'b1;
                    end
                end
`ifdef MSG_CRLF_EN
                S_EOL_CR: if (hs) tx_data <= 8'h0A;
                S_EOL_LF: if (hs) tx_valid <= 1'b0;
`endif
                S_DONE: msg_count <= msg_count + 16'd1;
                default: ;
            endcase
        end
    end

    assign o_rom_next  = (state == S_FETCH);
    assign o_busy      = (state != S_IDLE);
    assign o_done      = (state == S_DONE);
    assign o_tx_valid  = tx_valid;
    assign o_tx_data   = tx_data;
    assign o_overrun   = overrun;
    assign o_msg_count = msg_count;

endmodule

// File: tb/tb_msg_tx_sequencer.sv
// Bench for msg_tx_sequencer: ROM/sink responders, vector table, hand sequences and random messages
// checked against a message-level model (payload truncated at MAX_LEN, CR LF only after a NUL).
module tb_msg_tx_sequencer;

    localparam int PERIOD  = 20;
    localparam int MAX_LEN = 4;
`ifdef MSG_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic        i_clock;
    logic        i_reset_n;
    logic        i_start;
    logic        i_auto;
    logic        o_rom_next;
    logic        i_rom_act;
    logic [7:0]  i_rom_data;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_overrun;
    logic [15:0] o_msg_count;

    msg_tx_sequencer #(.PERIOD(PERIOD), .MAX_LEN(MAX_LEN)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n), .i_start(i_start), .i_auto(i_auto),
        .o_rom_next(o_rom_next), .i_rom_act(i_rom_act), .i_rom_data(i_rom_data),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun), .o_msg_count(o_msg_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] rom_mem [256];
    logic [7:0] rom_rd = 8'd0;
    int         rom_lat = 0;
    int         rdy_mode = 0;
    logic       man_rdy = 1'b0;

    logic [7:0] tx_log [1024];
    logic [9:0] tx_n = 10'd0;
    logic [7:0] done_cnt = 8'd0;
    int         done_cyc [256];
    int         next_cnt = 0;
    int         cyc = 0;
    int         stab_viol = 0;
    logic       hold_vld = 1'b0;
    logic [7:0] hold_dat = 8'h00;

    logic [7:0] m [8];
    int         model_cnt = 0;
    bit         model_ovr = 1'b0;

    typedef struct {
        logic [47:0] pay;
        int          plen;
        int          rmode;
        int          lat;
        int          exp_n;
        bit          exp_ovr;
    } vec_t;
    vec_t tbl [6];

    initial begin
        i_clock = 1'b0;
        forever #5 i_clock = ~i_clock;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ROM: answers each o_rom_next after rom_lat extra cycles
    initial begin
        i_rom_act  = 1'b0;
        i_rom_data = 8'h00;
        forever begin
            @(negedge i_clock);
            if (i_reset_n && o_rom_next) begin
                @(posedge i_clock);
                repeat (rom_lat) @(posedge i_clock);
                #1;
                i_rom_act  = 1'b1;
                i_rom_data = rom_mem[rom_rd];
                rom_rd     = rom_rd + 8'd1;
                @(posedge i_clock);
                #1;
                i_rom_act  = 1'b0;
                i_rom_data = 8'($urandom);
            end
        end
    end

    initial begin
        i_tx_ready = 1'b0;
        forever begin
            @(posedge i_clock);
            #2;
            case (rdy_mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = 1'($urandom);
                default: i_tx_ready = man_rdy;
            endcase
        end
    end

    initial begin
        forever begin
            @(negedge i_clock);
            cyc++;
            if (i_reset_n) begin
                if (o_tx_valid && i_tx_ready) begin
                    tx_log[tx_n] = o_tx_data;
                    tx_n = tx_n + 10'd1;
                end
                if (o_done) begin
                    done_cyc[done_cnt] = cyc;
                    done_cnt = done_cnt + 8'd1;
                end
                if (o_rom_next) next_cnt++;
                if (hold_vld && (!o_tx_valid || o_tx_data !== hold_dat)) stab_viol++;
                hold_vld = o_tx_valid && !i_tx_ready;
                hold_dat = o_tx_data;
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic wait_done(input logic [7:0] d0, input int budget, input string tag);
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge i_clock);
            k++;
        end
        #1;
        check({tag, " done_seen"}, 32'(done_cnt != d0), 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge i_clock); #1 i_start = 1'b1;
        @(posedge i_clock); #1 i_start = 1'b0;
    endtask

    task automatic do_msg(input int plen, input int exp_n, input bit term_ovr,
                          input int rmode, input int lat, input string tag);
        logic [7:0] base;
        logic [9:0] t0;
        logic [7:0] d0;
        int n0;
        int exp_tot;
        int got_tot;
        logic [7:0] e;
        rdy_mode = rmode;
        rom_lat  = lat;
        base = rom_rd;
        for (int i = 0; i < plen; i++) rom_mem[base + 8'(i)] = m[3'(i)];
        rom_mem[base + 8'(plen)] = 8'h00;
        t0 = tx_n; d0 = done_cnt; n0 = next_cnt;
        pulse_start();
        wait_done(d0, 600, tag);
        repeat (3) @(posedge i_clock);
        #1;
        model_cnt++;
        if (term_ovr) model_ovr = 1'b1;
        exp_tot = exp_n + ((CRLF && !term_ovr) ? 2 : 0);
        got_tot = int'(10'(tx_n - t0));
        check({tag, " tx_count"}, 32'(got_tot), 32'(exp_tot));
        for (int i = 0; i < exp_tot && i < got_tot; i++) begin
            if (i < exp_n)       e = m[3'(i)];
            else if (i == exp_n) e = 8'h0D;
            else                 e = 8'h0A;
            check({tag, " tx_byte"}, 32'(tx_log[t0 + 10'(i)]), 32'(e));
        end
        check({tag, " done_pulses"}, 32'(8'(done_cnt - d0)), 32'd1);
        check({tag, " rom_reads"}, 32'(next_cnt - n0), 32'(term_ovr ? exp_n : plen + 1));
        check({tag, " msg_count"}, 32'(o_msg_count), 32'(model_cnt & 16'hFFFF));
        check({tag, " overrun"}, 32'(o_overrun), 32'(model_ovr));
        check({tag, " idle"}, 32'(o_busy), 32'd0);
        check({tag, " tx_hold"}, 32'(stab_viol), 32'd0);
    endtask

    initial begin
        logic [7:0] base;
        logic [9:0] t0;
        logic [7:0] d0;
        logic [7:0] d1;
        int n0;
        int k;
        int plen;
        int bc;

        tbl[0] = '{{"Hi", 32'h0},     2, 0, 0, 2, 1'b0};
        tbl[1] = '{48'h0,             0, 0, 1, 0, 1'b0};
        tbl[2] = '{{"xyz", 24'h0},    3, 1, 2, 3, 1'b0};
        tbl[3] = '{{"ABC", 24'h0},    3, 1, 3, 3, 1'b0};
        tbl[4] = '{{"ABCD", 16'h0},   4, 1, 0, 4, 1'b1};
        tbl[5] = '{"012345",          6, 0, 1, 4, 1'b1};

        // Reset held with toggling inputs
        i_reset_n = 1'b0;
        i_start   = 1'b0;
        i_auto    = 1'b0;
        rdy_mode  = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge i_clock); #1;
            i_start = 1'($urandom);
            i_auto  = 1'($urandom);
            #3;
            check("reset_outputs", 32'({o_rom_next, o_tx_valid, o_tx_data, o_busy, o_done,
                                        o_overrun, o_msg_count}), 32'd0);
        end
        i_start = 1'b0;
        i_auto  = 1'b0;
        @(negedge i_clock); #1 i_reset_n = 1'b1;
        repeat (3) @(posedge i_clock);
        #1 check("post_reset_idle", 32'(o_busy), 32'd0);

        // Start latency and backpressure on the first byte
        rdy_mode = 2; man_rdy = 1'b0; rom_lat = 0;
        base = rom_rd;
        rom_mem[base] = 8'h48; rom_mem[base + 8'd1] = 8'h69; rom_mem[base + 8'd2] = 8'h00;
        t0 = tx_n; d0 = done_cnt;
        @(posedge i_clock); #1 i_start = 1'b1;
        @(posedge i_clock); #1 i_start = 1'b0;
        check("lat_still_idle", 32'(o_busy), 32'd0);
        @(posedge i_clock); #1;
        check("lat_fetch", 32'({o_busy, o_rom_next}), 32'd3);
        k = 0;
        while (!o_tx_valid && k < 20) begin @(posedge i_clock); #1; k++; end
        check("bp_valid", 32'(o_tx_valid), 32'd1);
        check("bp_data", 32'(o_tx_data), 32'h48);
        n0 = next_cnt;
        repeat (5) begin
            @(posedge i_clock); #1;
            check("bp_hold", 32'({o_tx_valid, o_tx_data}), 32'h148);
        end
        check("bp_no_fetch", 32'(next_cnt - n0), 32'd0);
        man_rdy = 1'b1;
        k = 0;
        while (next_cnt == n0 && k < 20) begin @(posedge i_clock); #1; k++; end
        check("bp_next_fetch", 32'(next_cnt - n0), 32'd1);
        check("bp_order", 32'(10'(tx_n - t0)), 32'd1);
        wait_done(d0, 100, "bp");
        repeat (3) @(posedge i_clock);
        #1;
        model_cnt = 1;
        check("bp_count", 32'(10'(tx_n - t0)), 32'(CRLF ? 4 : 2));
        check("bp_byte0", 32'(tx_log[t0]), 32'h48);
        check("bp_byte1", 32'(tx_log[t0 + 10'd1]), 32'h69);
        check("bp_msg_count", 32'(o_msg_count), 32'd1);
        rdy_mode = 0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 6; i++) m[3'(i)] = tbl[v].pay[47 - 8*i -: 8];
            do_msg(tbl[v].plen, tbl[v].exp_n, tbl[v].exp_ovr, tbl[v].rmode, tbl[v].lat,
                   $sformatf("vec%0d", v));
        end

        // Auto repeat every PERIOD, then three starts while busy coalesce into one
        rdy_mode = 0; rom_lat = 0;
        base = rom_rd;
        for (int c = 0; c < 8; c++) begin
            rom_mem[base + 8'(3*c)]     = 8'h61;
            rom_mem[base + 8'(3*c + 1)] = 8'h62;
            rom_mem[base + 8'(3*c + 2)] = 8'h00;
        end
        d0 = done_cnt;
        @(posedge i_clock); #1 i_auto = 1'b1;
        k = 0;
        while (8'(done_cnt - d0) < 8'd4 && k < 200) begin @(posedge i_clock); #1; k++; end
        check("auto_four_done", 32'(8'(done_cnt - d0)), 32'd4);
        for (int j = 0; j < 3; j++)
            check("auto_interval", 32'(done_cyc[d0 + 8'(j + 1)] - done_cyc[d0 + 8'(j)]), 32'(PERIOD));
        k = 0;
        while (!o_busy && k < 40) begin @(posedge i_clock); #1; k++; end
        d1 = done_cnt;
        for (int p = 0; p < 3; p++) begin
            check("coal_busy", 32'(o_busy), 32'd1);
            i_start = 1'b1;
            @(posedge i_clock); #1 i_start = 1'b0;
            @(posedge i_clock); #1;
        end
        i_auto = 1'b0;
        repeat (60) @(posedge i_clock);
        #1;
        check("coal_extra", 32'(8'(done_cnt - d1)), 32'd2);
        model_cnt += 6;

        for (int r = 0; r < 25; r++) begin
            plen = $urandom_range(0, 6);
            for (int i = 0; i < plen; i++) m[3'(i)] = 8'($urandom_range(1, 255));
            do_msg(plen, (plen < MAX_LEN) ? plen : MAX_LEN, plen >= MAX_LEN, 1,
                   $urandom_range(0, 3), "rand");
        end

        // Reset while a byte is waiting in SEND
        rdy_mode = 2; man_rdy = 1'b0; rom_lat = 0;
        base = rom_rd;
        rom_mem[base] = 8'h55; rom_mem[base + 8'd1] = 8'h00;
        pulse_start();
        k = 0;
        while (!o_tx_valid && k < 20) begin @(posedge i_clock); #1; k++; end
        check("rst_pre_valid", 32'(o_tx_valid), 32'd1);
        #1 i_reset_n = 1'b0;
        #1;
        check("rst_async", 32'({o_rom_next, o_tx_valid, o_tx_data, o_busy, o_done,
                                o_overrun, o_msg_count}), 32'd0);
        @(negedge i_clock); #1 i_reset_n = 1'b1;
        man_rdy = 1'b1; rdy_mode = 0;
        model_cnt = 0; model_ovr = 1'b0;
        bc = 0;
        repeat (30) begin @(posedge i_clock); #1; if (o_busy) bc++; end
        check("rst_stays_idle", 32'(bc), 32'd0);
        m[0] = 8'h48; m[1] = 8'h69;
        do_msg(2, 2, 1'b0, 0, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msg_tx_sequencer.md
# msg_tx_sequencer

Sequences a NUL-terminated message ROM (8-bit next/act/data stream) into a byte-wide transmit sink with a valid/ready handshake. It fetches one byte at a time, holds each byte until the sink accepts it, and detects the NUL terminator. It sends a message on a start pulse or periodically from an internal timer. It sits between the greeting ROM and the UART TX on the board top level.

## Interface
Parameters:
- PERIOD, 12000000: auto-repeat interval in i_clock cycles, ≥ 2.
- MAX_LEN, 100: maximum payload bytes per message before forced termination, ≥ 1.

Ports:
- i_clock  in  1  system clock; all logic is on the rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request to send one message.
- i_auto  in  1  level; enables periodic triggers from the PERIOD timer.
- o_rom_next  out  1  ROM byte request, one cycle per byte.
- i_rom_act  in  1  ROM byte valid.
- i_rom_data  in  8  ROM byte; 0x00 means end of message.
- o_tx_valid  out  1  TX byte valid.
- o_tx_data  out  8  TX byte.
- i_tx_ready  in  1  TX sink accepts the byte when both o_tx_valid and i_tx_ready are 1.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when a message ends.
- o_overrun  out  1  sticky flag; set when MAX_LEN is reached without a NUL.
- o_msg_count  out  16  number of completed messages; wraps modulo 2^16.

## Operation
- States: IDLE, FETCH, WAIT_ROM, SEND, EOL_CR, EOL_LF, DONE.
- Pending trigger flag:
  - Set by i_start=1, or by a timer wrap while i_auto=1.
  - Cleared when the block leaves IDLE.
  - If a trigger arrives in that same cycle, the flag stays set.
  - Triggers arriving while the flag is already set coalesce into one; extra triggers are dropped.
- PERIOD timer:
  - Free-running counter, 0..PERIOD-1.
  - A wrap to 0 is a trigger when i_auto=1.
  - It runs regardless of state.
- IDLE:
  - Pending flag set: go to FETCH and clear the byte count.
- FETCH:
  - o_rom_next=1 for exactly this cycle, then go to WAIT_ROM.
- WAIT_ROM: waits indefinitely for i_rom_act=1.
  - If i_rom_data=0x00, go to EOL_CR when the CRLF feature is compiled in, otherwise go to DONE.
  - If i_rom_data is nonzero, load it into o_tx_data, set o_tx_valid=1, increment the byte count, and go to SEND.
- SEND:
  - Hold o_tx_valid and o_tx_data until the handshake completes.
  - On handshake, drop o_tx_valid in the next cycle.
  - If the byte count equals MAX_LEN, set o_overrun and go to DONE; otherwise go to FETCH.
- EOL_CR and EOL_LF:
  - Same handshake as SEND, with bytes 0x0D and 0x0A respectively.
  - EOL_CR is followed by EOL_LF, then DONE.
- DONE:
  - o_done=1 for one cycle, o_msg_count increments, then go to IDLE.
- Byte count width: $clog2(MAX_LEN+1).
- On overrun the ROM is not rewound; recovering is the system's job (reset).

## Timing
- Reset values:
  - State IDLE, pending flag 0, timer 0.
  - All outputs 0: o_rom_next, o_tx_valid, o_tx_data=0x00, o_busy, o_done, o_overrun, o_msg_count.
- Reset is asynchronous. Asserting it mid-message forces all of the above immediately and drops any in-flight byte with no partial handshake.
- All outputs are registered or decoded from the registered state; there is no combinational path from input to output.
- Start latency:
  - i_start is sampled at edge t.
  - o_busy=1 and o_rom_next=1 during cycle t+1 when IDLE.
  - If the request arrives while busy, it is served one cycle after DONE.
- ROM contract: i_rom_act may rise at the earliest in the cycle after o_rom_next.
- Minimum per-byte cost: 3 cycles (FETCH, WAIT_ROM, SEND) with a zero-latency ROM and i_tx_ready tied to 1.
- o_tx_data must not change while o_tx_valid=1 and i_tx_ready=0.

## Configuration
- MSG_CRLF_EN defined:
  - After NUL, the block emits 0x0D and then 0x0A through the TX handshake before DONE.
  - CRLF is not appended after an overrun termination.
- MSG_CRLF_EN undefined:
  - EOL_CR and EOL_LF are absent; NUL goes directly to DONE.

## Test plan
- Reset check: hold i_reset_n=0 with random inputs -> all outputs 0 and o_busy=0.
- Basic message: ROM holds "Hi\0", i_tx_ready=1, pulse i_start.
  - Without MSG_CRLF_EN: TX sequence 0x48, 0x69; then o_done pulses once and o_msg_count=1.
  - With MSG_CRLF_EN: TX sequence 0x48, 0x69, 0x0D, 0x0A; then o_done pulses once and o_msg_count=1.
- Backpressure: hold i_tx_ready=0 for 5 cycles during 0x48 -> o_tx_valid stays 1 with data 0x48 stable; the next o_rom_next appears only after the handshake.
- Auto repeat and coalescing: PERIOD=20, i_auto=1, 2-byte message -> o_done every 20 cycles.
  - Add 3 i_start pulses while busy -> exactly one extra message.
- Overrun: MAX_LEN=4, ROM never returns 0x00 -> exactly 4 TX bytes, o_overrun=1 (stays set), o_done pulses once, no CRLF.
- Reset mid-SEND: pull i_reset_n low while o_tx_valid=1 -> o_tx_valid=0 with no clock edge; after release the block sits in IDLE until a new trigger.
